// File: rtl/io_pkg.sv
// Shared definitions for the configurable I/O tile: per-channel mode
// encodings and the number of configuration bits per channel.
package io_pkg;

   typedef enum logic [1:0] {
      IO_OFF = 2'b00,
      IO_G2S = 2'b01,
      IO_S2G = 2'b10,
      IO_RSV = 2'b11
   } io_mode_e;

   localparam int unsigned IO_CFG_BITS_PER_CH = 3;

endpackage

// File: rtl/io_chan_switch.sv
// One bidirectional channel switch: a fabric pin, a pad pin, an optional
// one-cycle registered path and the tristate drivers for both sides.
module io_chan_switch
   import io_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   inout  wire        port_g,
   inout  wire        port_s,
   input  logic [1:0] mode,
   input  logic       reg_en,
   input  logic       force_off
);

   logic path_q;
   logic g2s_c;
   logic s2g_c;

   // Direction decode; reserved and off leave both sides undriven.
   always_comb begin
      g2s_c = 1'b0;
      s2g_c = 1'b0;
      if (!force_off) begin
         g2s_c = (mode == IO_S2G) ? 1'b0 : (mode == IO_G2S);
         s2g_c = (mode == IO_S2G);
      end
   end

   // Registered path flop samples whichever side is the source every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         path_q <= 1'b0;
      end else begin
         path_q <= (mode == IO_S2G) ? port_s : port_g;
      end
   end

   // Tristate drivers; the source side is never driven.
   assign port_s = g2s_c ? (reg_en ? path_q : port_g) : 1'bz;
   assign port_g = s2g_c ? (reg_en ? path_q : port_s) : 1'bz;

endmodule

// File: rtl/io_block_param.sv
// Configurable I/O tile: N fabric/pad channel switches programmed from a
// daisy-chained serial bitstream. Optional serial readback of the shadow
// register is built when IO_CFG_READBACK_EN is defined.
module io_block_param
   import io_pkg::*;
#(
   parameter int unsigned N = 8
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         bit_in,
   input  logic         prgm_b,
   input  logic         io_prgm_b,
   input  logic         io_prgm_b_in,
   output logic         io_prgm_b_out,
   output logic         cfg_err,
`ifdef IO_CFG_READBACK_EN
   output logic         bit_out,
`endif
   inout  wire  [N-1:0] g,
   inout  wire  [N-1:0] s
);

   localparam int unsigned CFG_W = IO_CFG_BITS_PER_CH * N;
   localparam int unsigned CNT_W = $clog2(CFG_W + 1);

   logic [CFG_W-1:0] sr;
   logic [CFG_W-1:0] cfg;
   logic [CNT_W-1:0] cnt;
   logic             done;
   logic             prgm_b_q;

   logic [CFG_W-1:0] sr_d;
   logic [CFG_W-1:0] cfg_d;
   logic [CNT_W-1:0] cnt_d;
   logic             done_d;
   logic             cfg_err_d;
   logic             shift_en_c;
   logic             commit_c;
   logic             force_off_c;

   // Programming control: commit on prgm_b rising edge wins over shifting.
   always_comb begin
      sr_d        = sr;
      cfg_d       = cfg;
      cnt_d       = cnt;
      done_d      = done;
      cfg_err_d   = cfg_err;
      force_off_c = ~prgm_b;
      commit_c    = prgm_b & ~prgm_b_q;
      shift_en_c  = ~prgm_b & ~io_prgm_b & ~io_prgm_b_in & ~done;
      if (commit_c) begin
         if (done) begin
            cfg_d = sr;
         end else begin
            cfg_err_d = 1'b1;
         end
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (shift_en_c) begin
         sr_d  = {sr[CFG_W-2:0], bit_in};
         cnt_d = cnt + CNT_W'(1);
         if (cnt == CNT_W'(CFG_W - 1)) begin
            done_d = 1'b1;
         end
      end
   end

   // Configuration state and token register; prgm_b_q idles high so a
   // reset release with prgm_b high is not seen as a commit edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr            <= '0;
         cfg           <= '0;
         cnt           <= '0;
         done          <= 1'b0;
         cfg_err       <= 1'b0;
         prgm_b_q      <= 1'b1;
         io_prgm_b_out <= 1'b1;
      end else begin
         sr            <= sr_d;
         cfg           <= cfg_d;
         cnt           <= cnt_d;
         done          <= done_d;
         cfg_err       <= cfg_err_d;
         prgm_b_q      <= prgm_b;
         io_prgm_b_out <= ~done_d;
      end
   end

`ifdef IO_CFG_READBACK_EN
   // Readback taps the shadow MSB so old contents stream out while shifting.
   assign bit_out = sr[CFG_W-1];
`endif

   // One switch per channel, fed from its slice of the active configuration.
   for (genvar k = 0; k < int'(N); k++) begin : g_ch
      io_chan_switch u_sw (
         .clk       (clk),
         .reset     (reset),
         .port_g    (g[k]),
         .port_s    (s[k]),
         .mode      (cfg[IO_CFG_BITS_PER_CH*k +: 2]),
         .reg_en    (cfg[IO_CFG_BITS_PER_CH*k + 2]),
         .force_off (force_off_c)
      );
   end

endmodule

// File: tb/tb_io_block_param.sv
// Scoreboard bench for io_block_param: two chained tiles, pulled-up pins
// so an undriven pin reads 1, expectations queued and checked on negedge.
module tb_io_block_param;

   localparam int unsigned N     = 8;
   localparam int unsigned CFG_W = 24;

   logic clk;
   logic reset;
   logic bit_in;
   logic prgm_b;
   logic io_prgm_b;
   logic a_tok;
   logic b_tok;
   logic a_err;
   logic b_err;
`ifdef IO_CFG_READBACK_EN
   logic a_bout;
   logic b_bout;
`endif

   wire  [N-1:0] ga, sa, gb, sb;
   logic [N-1:0] ga_en, ga_drv, sa_en, sa_drv, gb_en, gb_drv, sb_en, sb_drv;

   for (genvar i = 0; i < int'(N); i++) begin : g_pin
      assign ga[i] = ga_en[i] ? ga_drv[i] : 1'bz;
      assign sa[i] = sa_en[i] ? sa_drv[i] : 1'bz;
      assign gb[i] = gb_en[i] ? gb_drv[i] : 1'bz;
      assign sb[i] = sb_en[i] ? sb_drv[i] : 1'bz;
      pullup (ga[i]);
      pullup (sa[i]);
      pullup (gb[i]);
      pullup (sb[i]);
   end

   io_block_param #(.N(N)) u_a (
      .clk           (clk),
      .reset         (reset),
      .bit_in        (bit_in),
      .prgm_b        (prgm_b),
      .io_prgm_b     (io_prgm_b),
      .io_prgm_b_in  (1'b0),
      .io_prgm_b_out (a_tok),
      .cfg_err       (a_err),
`ifdef IO_CFG_READBACK_EN
      .bit_out       (a_bout),
`endif
      .g             (ga),
      .s             (sa)
   );

   io_block_param #(.N(N)) u_b (
      .clk           (clk),
      .reset         (reset),
      .bit_in        (bit_in),
      .prgm_b        (prgm_b),
      .io_prgm_b     (io_prgm_b),
      .io_prgm_b_in  (a_tok),
      .io_prgm_b_out (b_tok),
      .cfg_err       (b_err),
`ifdef IO_CFG_READBACK_EN
      .bit_out       (b_bout),
`endif
      .g             (gb),
      .s             (sb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string            name;
      logic [N-1:0]     ga, sa, gb, sb;
      logic             atok, btok, aerr, berr;
      logic [CFG_W-1:0] cfga, cfgb;
      logic             rb, abo, bbo;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   tests  = 0;
   int   failed = 0;

   // Expected tile state, maintained by the stimulus process.
   logic [N-1:0]     e_ga, e_sa, e_gb, e_sb;
   logic             e_atok, e_btok, e_aerr, e_berr;
   logic [CFG_W-1:0] e_cfga, e_cfgb;
   logic             e_rb, e_abo, e_bbo;

   task automatic cmp(input string n, input string f,
                      input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s.%s: got %h, want %h", n, f, act, exp);
      end
   endtask

   // Monitor: drain every queued expectation against the live DUT outputs.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         cmp(mon_e.name, "ga",   CFG_W'(ga),        CFG_W'(mon_e.ga));
         cmp(mon_e.name, "sa",   CFG_W'(sa),        CFG_W'(mon_e.sa));
         cmp(mon_e.name, "gb",   CFG_W'(gb),        CFG_W'(mon_e.gb));
         cmp(mon_e.name, "sb",   CFG_W'(sb),        CFG_W'(mon_e.sb));
         cmp(mon_e.name, "atok", CFG_W'(a_tok),     CFG_W'(mon_e.atok));
         cmp(mon_e.name, "btok", CFG_W'(b_tok),     CFG_W'(mon_e.btok));
         cmp(mon_e.name, "aerr", CFG_W'(a_err),     CFG_W'(mon_e.aerr));
         cmp(mon_e.name, "berr", CFG_W'(b_err),     CFG_W'(mon_e.berr));
         cmp(mon_e.name, "cfga", CFG_W'(u_a.cfg),   mon_e.cfga);
         cmp(mon_e.name, "cfgb", CFG_W'(u_b.cfg),   mon_e.cfgb);
`ifdef IO_CFG_READBACK_EN
         if (mon_e.rb) begin
            cmp(mon_e.name, "abo", CFG_W'(a_bout), CFG_W'(mon_e.abo));
            cmp(mon_e.name, "bbo", CFG_W'(b_bout), CFG_W'(mon_e.bbo));
         end
`endif
      end
   end

   task automatic chk(input string name);
      exp_t e;
      e.name = name;
      e.ga = e_ga;  e.sa = e_sa;  e.gb = e_gb;  e.sb = e_sb;
      e.atok = e_atok;  e.btok = e_btok;  e.aerr = e_aerr;  e.berr = e_berr;
      e.cfga = e_cfga;  e.cfgb = e_cfgb;
      e.rb = e_rb;  e.abo = e_abo;  e.bbo = e_bbo;
      sb_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Shift v[n-1] first down to v[0]; io_prgm_b is only low while shifting.
   task automatic send(input logic [47:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         bit_in    = v[i];
         io_prgm_b = 1'b0;
         tick();
      end
      io_prgm_b = 1'b1;
   endtask

   task automatic commit();
      prgm_b = 1'b1;
      tick();
   endtask

   task automatic exp_reset();
      e_ga = '1;  e_sa = '1;  e_gb = '1;  e_sb = '1;
      e_atok = 1'b1;  e_btok = 1'b1;  e_aerr = 1'b0;  e_berr = 1'b0;
      e_cfga = '0;  e_cfgb = '0;
      e_rb = 1'b0;  e_abo = 1'b0;  e_bbo = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      logic [47:0]      full;
      logic [CFG_W-1:0] pat_a;
      logic [CFG_W-1:0] pat_b;

      reset = 1'b1;  prgm_b = 1'b1;  io_prgm_b = 1'b1;  bit_in = 1'b0;
      ga_en = '0;  ga_drv = '0;  sa_en = '0;  sa_drv = '0;
      gb_en = '0;  gb_drv = '0;  sb_en = '0;  sb_drv = '0;
      exp_reset();
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("reset");

      // Channel 0 unregistered g->s.
      prgm_b = 1'b0;
      chk("prog_idle");
      send(48'h0, 23);
      chk("tok_before_last");
      send(48'h1, 1);
      e_atok = 1'b0;
      chk("tok_after_last");
      commit();
      e_atok = 1'b1;  e_cfga = 24'h000001;  e_berr = 1'b1;
      chk("commit_ch0");
      ga_en[0] = 1'b1;  ga_drv[0] = 1'b0;
      e_ga = 8'hFE;  e_sa = 8'hFE;
      chk("g2s_low");
      ga_drv[0] = 1'b1;
      e_ga = 8'hFF;  e_sa = 8'hFF;
      chk("g2s_high");
      ga_drv[0] = 1'b0;  prgm_b = 1'b0;
      e_ga = 8'hFE;  e_sa = 8'hFF;
      chk("forced_off");
      ga_en = '0;
      e_ga = 8'hFF;

      // Channel 3 registered s->g.
      send(48'h000C00, 24);
      commit();
      e_cfga = 24'h000C00;
      sa_en[3] = 1'b1;  sa_drv[3] = 1'b0;
      tick();
      e_ga = 8'hF7;  e_sa = 8'hF7;
      chk("s2g_reg_low");
      tick();
      sa_drv[3] = 1'b1;
      e_sa = 8'hFF;
      chk("s2g_reg_hold");
      tick();
      e_ga = 8'hFF;
      chk("s2g_reg_rise");

      // Incomplete bitstream: token never passes, cfg kept, error flagged.
      prgm_b = 1'b0;
      send(48'h5A5A5, 20);
      chk("partial_tok");
      commit();
      e_aerr = 1'b1;
      chk("partial_commit");

      // Two chained tiles share one 48-bit stream and one commit edge.
      sa_en = '0;
      prgm_b = 1'b0;
      full = {24'h000008, 24'h000040};
      send(full >> 25, 23);
      chk("chain_tok_hold");
      send(48'(full[24]), 1);
      e_atok = 1'b0;
      chk("chain_tok_fall");
      send(48'(full[23:0]), 24);
      e_btok = 1'b0;
      chk("chain_b_done");
      commit();
      e_atok = 1'b1;  e_btok = 1'b1;  e_cfga = 24'h000008;  e_cfgb = 24'h000040;
      chk("chain_commit");
      ga_en[1] = 1'b1;  ga_drv[1] = 1'b0;
      gb_en[2] = 1'b1;  gb_drv[2] = 1'b0;
      e_ga = 8'hFD;  e_sa = 8'hFD;  e_gb = 8'hFB;  e_sb = 8'hFB;
      chk("chain_pins");

      // Reset part-way through a session, then a clean session.
      ga_en = '0;  gb_en = '0;
      prgm_b = 1'b0;
      send(48'h3FF, 10);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_reset();
      chk("mid_reset");
      ga_en[4] = 1'b1;  ga_drv[4] = 1'b0;
      e_ga = 8'hEF;
      send(48'h005000, 24);
      commit();
      e_cfga = 24'h005000;  e_berr = 1'b1;  e_sa = 8'hEF;
      chk("reset_restart");
      tick();
      ga_drv[4] = 1'b1;
      e_ga = 8'hFF;
      chk("g2s_reg_hold");
      tick();
      e_sa = 8'hFF;
      chk("g2s_reg_rise");

`ifdef IO_CFG_READBACK_EN
      // Old shadow contents emerge MSB-first while a new pattern shifts in.
      prgm_b = 1'b0;
      pat_a = 24'h005000;
      pat_b = 24'h00A5A5;
      e_rb = 1'b1;  e_bbo = 1'b0;
      for (int i = 0; i < int'(CFG_W); i++) begin
         e_abo = pat_a[CFG_W-1-i];
         chk("readback");
         bit_in    = pat_b[CFG_W-1-i];
         io_prgm_b = 1'b0;
         tick();
      end
      io_prgm_b = 1'b1;
      e_atok = 1'b0;
      e_abo  = pat_b[CFG_W-1];
      chk("readback_done");
`else
      pat_a = '0;
      pat_b = '0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
